weight_pingpong_buffer: RTL and testbench

WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

---
 rtl/wpb_pkg.sv | 17 +
 rtl/wpb_bank.sv | 23 ++
 rtl/weight_pingpong_buffer.sv | 180 ++++++++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wpb_pkg.sv
// Shared types and size helpers for the weight ping-pong buffer.
package wpb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} fetch_state_t;

  localparam int WPB_DW     = 32;
  localparam int BEAT_BYTES = WPB_DW / 8;

  function automatic int depth_f(input int ksize, input int pw_len);
    return (ksize * ksize > pw_len) ? ksize * ksize : pw_len;
  endfunction

  function automatic int klen_f(input logic mode, input int ksize, input int pw_len);
    return mode ? pw_len : ksize * ksize;
  endfunction

endpackage

// File: rtl/wpb_bank.sv
// One weight bank: DEPTH x DW register file, one write port, one async read port.
module wpb_bank #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 32,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ridx,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered kernel-weight fetcher: burst reads fill one bank while the other streams out.
// Optional WEIGHT_BUF_RLAST_CHK_EN adds a sticky err output for rlast/beat-count disagreement.
module weight_pingpong_buffer
  import wpb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int KSIZE  = 3,
  parameter int PW_LEN = 32,
  parameter int BURST  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          weight_load,
  input  logic          init_addr_en,
  input  logic [AW-1:0] init_addr,
  input  logic          mode,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  output logic [3:0]    arburst,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  input  logic          rlast,
  output logic [DW-1:0] wt_out,
  output logic          wt_valid,
  input  logic          wt_ready,
  output logic          wt_last,
  output logic          dw_comp,
`ifdef WEIGHT_BUF_RLAST_CHK_EN
  output logic          err,
`endif
  output logic          busy
);

  localparam int DEPTH = depth_f(KSIZE, PW_LEN);
  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(BURST + 1);

  fetch_state_t state, state_d;

  logic [AW-1:0] ptr, pend_addr, l_addr;
  logic [CW-1:0] rem, idx, rd_idx, fill_klen, drain_klen, l_klen;
  logic [BW-1:0] burst_beats;
  logic          fill_sel, fill_full, drain_full;
  logic          pend_vld, pend_en, pend_mode, l_en, l_mode;
  logic          launch, store_new, ar_hs, beat, set_done, swap, wt_hs, last_hs;
  logic [1:0]          bank_we;
  logic [1:0][DW-1:0]  bank_rd;

  // A pending request always wins the launch slot over a fresh pulse.
  assign launch    = (state == IDLE) && !fill_full && (pend_vld || weight_load);
  assign l_addr    = pend_vld ? pend_addr : init_addr;
  assign l_en      = pend_vld ? pend_en   : init_addr_en;
  assign l_mode    = pend_vld ? pend_mode : mode;
  assign l_klen    = CW'(klen_f(l_mode, KSIZE, PW_LEN));
  assign store_new = weight_load && (pend_vld ? launch : !launch);

  assign burst_beats = (int'(rem) > BURST) ? BW'(BURST) : BW'(rem);
  assign ar_hs       = arvalid && arready;
  assign beat        = (state == DATA) && rvalid;
  assign set_done    = beat && rlast && (rem == '0);
  assign swap        = fill_full && !drain_full;
  assign wt_hs       = drain_full && wt_ready;
  assign last_hs     = wt_hs && wt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    arvalid = 1'b0;
    araddr  = '0;
    arburst = '0;
    case (state)
      IDLE: if (launch) state_d = ADDR;
      ADDR: begin
        arvalid = 1'b1;
        araddr  = ptr;
        arburst = 4'(burst_beats - BW'(1));
        if (arready) state_d = DATA;
      end
      DATA: if (rvalid && rlast) state_d = (rem != '0) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      rem        <= '0;
      idx        <= '0;
      rd_idx     <= '0;
      fill_klen  <= '0;
      drain_klen <= '0;
      fill_sel   <= 1'b0;
      fill_full  <= 1'b0;
      drain_full <= 1'b0;
      dw_comp    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      pend_en    <= 1'b0;
      pend_mode  <= 1'b0;
    end else begin
      if (launch) begin
        if (l_en) ptr <= l_addr;
        rem       <= l_klen;
        fill_klen <= l_klen;
        idx       <= '0;
      end
      if (ar_hs) begin
        ptr <= ptr + AW'(BEAT_BYTES) * AW'(burst_beats);
        rem <= rem - CW'(burst_beats);
      end
      if (beat)     idx       <= idx + CW'(1);
      if (set_done) fill_full <= 1'b1;
      // Swap hands the filled bank (and its set length) to the drain side.
      if (swap) begin
        fill_full  <= 1'b0;
        drain_full <= 1'b1;
        fill_sel   <= ~fill_sel;
        drain_klen <= fill_klen;
        rd_idx     <= '0;
      end
      if (wt_hs)   rd_idx     <= last_hs ? '0 : rd_idx + CW'(1);
      if (last_hs) drain_full <= 1'b0;
      dw_comp <= last_hs;
      if (store_new) begin
        pend_vld  <= 1'b1;
        pend_addr <= init_addr;
        pend_en   <= init_addr_en;
        pend_mode <= mode;
      end else if (launch && pend_vld) begin
        pend_vld <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = beat && (fill_sel == 1'(b)) && (int'(idx) < DEPTH);
    wpb_bank #(.DW(DW), .DEPTH(DEPTH)) u_bank (
      .clk  (clk),
      .we   (bank_we[b]),
      .widx (idx[IW-1:0]),
      .wdata(rdata),
      .ridx (rd_idx[IW-1:0]),
      .rdata(bank_rd[b])
    );
  end

  assign wt_valid = drain_full;
  assign wt_out   = drain_full ? bank_rd[~fill_sel] : '0;
  assign wt_last  = drain_full && (rd_idx == drain_klen - CW'(1));
  assign busy     = (state != IDLE) || pend_vld;

`ifdef WEIGHT_BUF_RLAST_CHK_EN
  logic [BW-1:0] beats_q, bcnt;

  // Sticky: rlast must coincide exactly with the last beat we asked for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      beats_q <= '0;
      bcnt    <= '0;
    end else begin
      if (ar_hs) begin
        beats_q <= burst_beats;
        bcnt    <= '0;
      end else if (beat) begin
        bcnt <= bcnt + BW'(1);
      end
      if (beat && (rlast != (bcnt == beats_q - BW'(1)))) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Self-checking bench: queue-based model of address bursts and the weight stream.
module tb_weight_pingpong_buffer;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        weight_load = 1'b0, init_addr_en = 1'b0, mode = 1'b0;
  logic [31:0] init_addr = '0, rdata = '0;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, wt_ready = 1'b0;
  logic [31:0] araddr, wt_out;
  logic [3:0]  arburst;
  logic        arvalid, wt_valid, wt_last, dw_comp, busy;
`ifdef WEIGHT_BUF_RLAST_CHK_EN
  logic        err;
`endif

  weight_pingpong_buffer dut (
    .clk(clk), .rst_n(rst_n), .weight_load(weight_load), .init_addr_en(init_addr_en),
    .init_addr(init_addr), .mode(mode), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .arburst(arburst), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .wt_out(wt_out), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_last(wt_last),
    .dw_comp(dw_comp),
`ifdef WEIGHT_BUF_RLAST_CHK_EN
    .err(err),
`endif
    .busy(busy)
  );

  typedef struct packed { logic [31:0] a; logic [3:0] b; } ar_t;
  typedef struct packed { logic [31:0] d; logic l; } wd_t;

  ar_t ar_q[$], ar_log[$], bq[$];
  wd_t wd_q[$];
  logic [31:0] mptr = '0, cur_addr = '0;
  int   errors = 0, checks = 0, cyc = 0;
  int   cur_left = 0, ar_wait = 0, ar_delay = 0, beats_sent = 0;
  int   last_rlast_cyc = 0, wv_rise_cyc = 0, dwc_cnt = 0;
  bit   sink_en = 1'b1, exp_dwc = 1'b0, wv_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got a transfer expected none", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Issue one load pulse and append the set it must produce to the model queues.
  task automatic load(input logic m, input logic en, input logic [31:0] a);
    int klen;
    int n;
    klen = m ? 32 : 9;
    @(negedge clk);
    weight_load = 1'b1; mode = m; init_addr_en = en; init_addr = a;
    if (en) mptr = a;
    for (int i = 0; i < klen; i++) wd_q.push_back('{d: mem_word(mptr + 32'(4 * i)), l: (i == klen - 1)});
    for (int o = 0; o < klen; o += 16) begin
      n = (klen - o > 16) ? 16 : klen - o;
      ar_q.push_back('{a: mptr + 32'(4 * o), b: 4'(n - 1)});
    end
    mptr += 32'(4 * klen);
    @(negedge clk);
    weight_load = 1'b0; init_addr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((ar_q.size() != 0 || wd_q.size() != 0 || busy || wt_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 64'(n < 600), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_arvalid"}, arvalid, 0);
    chk({name, "_wt_valid"}, wt_valid, 0);
    chk({name, "_wt_last"}, wt_last, 0);
    chk({name, "_dw_comp"}, dw_comp, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_araddr"}, araddr, 0);
    chk({name, "_arburst"}, arburst, 0);
    chk({name, "_wt_out"}, wt_out, 0);
  endtask

  // Memory slave: one beat per cycle; keeps streaming an in-flight burst through reset.
  initial begin
    forever begin
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
      if (cur_left == 0 && bq.size() > 0) begin
        ar_t t;
        t = bq.pop_front();
        cur_addr = t.a;
        cur_left = int'(t.b) + 1;
      end
      if (cur_left > 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(cur_addr);
        rlast  = (cur_left == 1);
        if (cur_left == 1) last_rlast_cyc = cyc;
        cur_addr += 32'd4;
        cur_left--;
        beats_sent++;
      end
      arready = 1'b0;
      if (rst_n && arvalid) begin
        if (ar_q.size() == 0) fail_unexp("ar_unexpected");
        else begin
          chk("araddr", araddr, ar_q[0].a);
          chk("arburst", arburst, ar_q[0].b);
          if (ar_wait >= ar_delay) begin
            arready = 1'b1;
            ar_wait = 0;
            ar_log.push_back('{a: araddr, b: arburst});
            bq.push_back('{a: araddr, b: arburst});
            void'(ar_q.pop_front());
          end else ar_wait++;
        end
      end else ar_wait = 0;
    end
  end

  // Sink + per-cycle compare of the weight stream and dw_comp.
  initial begin
    forever begin
      @(negedge clk);
      wt_ready = sink_en;
      if (!rst_n) begin
        exp_dwc = 1'b0;
        wv_prev = 1'b0;
      end else begin
        chk("dw_comp", dw_comp, exp_dwc);
        if (dw_comp) dwc_cnt++;
        exp_dwc = 1'b0;
        if (wt_valid && !wv_prev) wv_rise_cyc = cyc;
        wv_prev = wt_valid;
        if (wt_valid) begin
          if (wd_q.size() == 0) fail_unexp("wt_unexpected");
          else begin
            chk("wt_out", wt_out, wd_q[0].d);
            chk("wt_last", wt_last, wd_q[0].l);
            if (wt_ready) begin
              exp_dwc = wd_q[0].l;
              void'(wd_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int n, base, t_d;
    #1 reset_checks("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Depthwise set from 0x0: one 9-beat burst.
    ar_log.delete(); dwc_cnt = 0;
    load(1'b0, 1'b1, 32'h0);
    chk("t1_arvalid_latency", arvalid, 1);
    wait_idle("t1");
    chk("t1_ar_count", ar_log.size(), 1);
    if (ar_log.size() > 0) begin
      chk("t1_araddr", ar_log[0].a, 32'h0);
      chk("t1_arburst", ar_log[0].b, 8);
    end
    chk("t1_dwc_count", dwc_cnt, 1);
    chk("t1_rlast_to_valid", wv_rise_cyc - last_rlast_cyc, 2);

    // Continuation without init_addr_en.
    ar_log.delete();
    load(1'b0, 1'b0, 32'hDEAD_0000);
    wait_idle("t2");
    chk("t2_ar_count", ar_log.size(), 1);
    if (ar_log.size() > 0) chk("t2_araddr", ar_log[0].a, 32'h24);

    // Pointwise set at 0x100: two 16-beat bursts.
    ar_log.delete(); dwc_cnt = 0;
    load(1'b1, 1'b1, 32'h100);
    wait_idle("t3");
    chk("t3_ar_count", ar_log.size(), 2);
    if (ar_log.size() > 1) begin
      chk("t3_araddr0", ar_log[0].a, 32'h100);
      chk("t3_araddr1", ar_log[1].a, 32'h140);
      chk("t3_arburst0", ar_log[0].b, 15);
      chk("t3_arburst1", ar_log[1].b, 15);
    end
    chk("t3_dwc_count", dwc_cnt, 1);

    // Slow arready: address must hold while waiting.
    ar_log.delete(); ar_delay = 5;
    load(1'b1, 1'b0, 32'h0);
    wait_idle("t4");
    ar_delay = 0;
    if (ar_log.size() > 0) chk("t4_araddr0", ar_log[0].a, 32'h180);

    // Both banks fill with the sink stalled; third load must wait in the pending slot.
    ar_log.delete(); sink_en = 1'b0;
    load(1'b0, 1'b1, 32'h400);
    n = 0;
    while (!wt_valid && n < 200) begin @(negedge clk); n++; end
    chk("t5_first_set", 64'(n < 200), 1);
    load(1'b0, 1'b0, 32'h0);
    n = 0;
    while ((ar_q.size() != 0 || busy || cur_left != 0) && n < 200) begin @(negedge clk); n++; end
    chk("t5_second_set", 64'(n < 200), 1);
    repeat (3) @(negedge clk);
    load(1'b1, 1'b0, 32'h0);
    repeat (20) @(negedge clk);
    chk("t5_busy_pending", busy, 1);
    chk("t5_no_arvalid", arvalid, 0);
    chk("t5_drain_held", wt_valid, 1);
    chk("t5_ar_count", ar_log.size(), 2);
    sink_en = 1'b1;
    n = 0;
    while (!dw_comp && n < 100) begin @(negedge clk); n++; end
    chk("t5_drain_done", 64'(n < 100), 1);
    t_d = cyc;
    n = 0;
    while (!arvalid && n < 20) begin @(negedge clk); n++; end
    chk("t5_launch_soon", 64'((cyc - t_d) >= 1 && (cyc - t_d) <= 3), 1);
    wait_idle("t5");
    chk("t5_ar_total", ar_log.size(), 4);
    if (ar_log.size() > 2) chk("t5_araddr_c", ar_log[2].a, 32'h448);

    // Reset in the middle of a burst, then a fresh load.
    base = beats_sent;
    load(1'b1, 1'b1, 32'h800);
    n = 0;
    while (beats_sent < base + 4 && n < 100) begin @(negedge clk); n++; end
    chk("t6_reached_beat4", 64'(n < 100), 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("t6");
    ar_q.delete(); wd_q.delete(); mptr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("t6_idle_after_stray", {busy, wt_valid, arvalid}, 0);
    ar_log.delete();
    load(1'b0, 1'b1, 32'h40);
    wait_idle("t6");
    chk("t6_ar_count", ar_log.size(), 1);
    if (ar_log.size() > 0) chk("t6_araddr", ar_log[0].a, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
